// File: rtl/hazard_dest_pipe.sv
// hazard_dest_pipe: producer side of the EX/MEM forwarding interface.
// Carries destination-register and write-control fields from ID through EX
// and MEM (and WB when WB_FWD_EN is defined), detects load-use hazards,
// inserts bubbles, honours branch flush and global memory stall, drives the
// PC / IF/ID write enables and keeps a saturating stall-cycle counter.
// Optional feature macro: WB_FWD_EN (adds wb_rd / wb_reg_write outputs).
module hazard_dest_pipe #(
    parameter int RD_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RD_W-1:0]  id_rs,
    input  logic [RD_W-1:0]  id_rt,
    input  logic [RD_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_uses_rt,
    input  logic             flush_ex,
    input  logic             ext_stall,
    output logic [RD_W-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [RD_W-1:0]  mem_rd,
    output logic             mem_reg_write,
`ifdef WB_FWD_EN
    output logic [RD_W-1:0]  wb_rd,
    output logic             wb_reg_write,
`endif
    output logic             pc_write,
    output logic             if_id_write,
    output logic             lu_stall,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LU   = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic hz;
    logic advance;
    logic bubble;
    logic id_write_live;
    logic id_load_live;

    assign state = state_q;

    // A $zero destination is never carried as a live write.
    assign id_write_live = id_valid & id_reg_write & (id_rd != '0);
    assign id_load_live  = id_valid & id_mem_read;

    // Load in EX whose destination is read by the instruction in ID.
    assign hz = id_valid & ex_mem_read & ex_reg_write &
                ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and enables; priority ext_stall > flush_ex > hazard > advance.
    always_comb begin
        state_d     = RUN;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        lu_stall    = 1'b0;
        advance     = 1'b1;
        bubble      = 1'b0;
        if (ext_stall) begin
            state_d     = HOLD;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            advance     = 1'b0;
        end else if (flush_ex) begin
            bubble = 1'b1;
        end else if (hz) begin
            state_d     = LU;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            lu_stall    = 1'b1;
            bubble      = 1'b1;
        end
    end

    // Stage registers: EX from ID (or bubble), MEM from EX, all held on ext_stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
        end else if (advance) begin
            if (bubble) begin
                ex_rd        <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                ex_rd        <= id_rd;
                ex_reg_write <= id_write_live;
                ex_mem_read  <= id_load_live;
            end
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
        end
    end

`ifdef WB_FWD_EN
    // WB stage fields for the third forwarding source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else if (advance) begin
            wb_rd        <= mem_rd;
            wb_reg_write <= mem_reg_write;
        end
    end
`endif

    // Saturating count of load-use and external stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((lu_stall | ext_stall) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Self-checking bench for hazard_dest_pipe: per-scenario stimulus tables,
// expected registered state queued at drive time and compared after the edge.
module tb_hazard_dest_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_uses_rt;
    logic        flush_ex;
    logic        ext_stall;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
`ifdef WB_FWD_EN
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
`endif
    logic        pc_write;
    logic        if_id_write;
    logic        lu_stall;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    hazard_dest_pipe #(.RD_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_uses_rt(id_uses_rt), .flush_ex(flush_ex), .ext_stall(ext_stall),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
`ifdef WB_FWD_EN
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
`endif
        .pc_write(pc_write), .if_id_write(if_id_write), .lu_stall(lu_stall),
        .state(state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  ex_rd;
        logic        ex_rw;
        logic        ex_mr;
        logic [4:0]  mem_rd;
        logic        mem_rw;
        logic [1:0]  st;
        logic [15:0] cnt;
    } snap_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       urt;
        logic       fl;
        logic       xs;
        logic       en;
        logic       lu;
        snap_t      exp;
    } step_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    snap_t       q[$];
    snap_t       e;
    snap_t       o;

    function automatic snap_t obs();
        return {ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, state, stall_cnt};
    endfunction

    function automatic step_t st(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                 logic rw, logic mr, logic urt, logic fl, logic xs,
                                 logic en, logic lu,
                                 logic [4:0] erd, logic erw, logic emr,
                                 logic [4:0] mrd, logic mrw, logic [1:0] est, logic [15:0] ecnt);
        step_t s;
        s.v = v; s.rs = rs; s.rt = rt; s.rd = rd; s.rw = rw; s.mr = mr; s.urt = urt;
        s.fl = fl; s.xs = xs; s.en = en; s.lu = lu;
        s.exp = {erd, erw, emr, mrd, mrw, est, ecnt};
        return s;
    endfunction

    task automatic drive(input step_t s);
        id_valid = s.v; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_reg_write = s.rw; id_mem_read = s.mr; id_uses_rt = s.urt;
        flush_ex = s.fl; ext_stall = s.xs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t idle;
        idle = st(0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,0,0,2'd0,16'd0);
        rst = 1'b1;
        drive(idle);
        tick();
        tick();
        n_cmp++;
        if (obs() !== snap_t'(0) || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_initial: got regs=%h pc/ifid=%b%b want 0 and 11", obs(), pc_write, if_id_write);
        end
        rst = 1'b0;
        drive(st(1,0,0,7, 1,1,0,0,0, 1,0, 0,0,0,0,0,2'd0,16'd0));
        tick();
        drive(st(1,7,0,3, 1,0,0,0,0, 0,1, 0,0,0,0,0,2'd0,16'd0));
        #1;
        n_cmp++;
        if (lu_stall !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_prehz: got lu_stall=%b want 1", lu_stall);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== snap_t'(0) || pc_write !== 1'b1 || if_id_write !== 1'b1 || lu_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: got regs=%h pc/ifid/lu=%b%b%b want 0 and 110",
                     obs(), pc_write, if_id_write, lu_stall);
        end
        tick();
        n_cmp++;
        if (obs() !== snap_t'(0)) begin
            n_bad++;
            $display("FAIL reset_held: got %h want 0", obs());
        end
        drive(idle);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        step_t sv[$];
        sv.push_back(st(1,0,0,5, 1,0,0,0,0, 1,0, 5,1,0,0,0,2'd0,16'd0));
        sv.push_back(st(1,0,0,5, 1,0,0,0,0, 1,0, 5,1,0,5,1,2'd0,16'd0));
        sv.push_back(st(0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,5,1,2'd0,16'd0));
        foreach (sv[i]) begin
            drive(sv[i]);
            #1;
            n_cmp++;
            if ({pc_write, if_id_write, lu_stall} !== {sv[i].en, sv[i].en, sv[i].lu}) begin
                n_bad++;
                $display("FAIL b2b_comb[%0d]: got pc/ifid/lu=%b%b%b want %b%b%b", i,
                         pc_write, if_id_write, lu_stall, sv[i].en, sv[i].en, sv[i].lu);
            end
            q.push_back(sv[i].exp);
            tick();
            e = q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b_regs[%0d]: got %h want %h", i, o, e);
            end
        end
`ifdef WB_FWD_EN
        n_cmp++;
        if (wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_wb: got %0d/%b want 5/1", wb_rd, wb_reg_write);
        end
`endif
    endtask

    task automatic test_load_use();
        step_t sv[$];
        sv.push_back(st(1,0,0,8, 1,1,0,0,0, 1,0, 8,1,1,0,0,2'd0,16'd0));
        sv.push_back(st(1,8,3,9, 1,0,1,0,0, 0,1, 0,0,0,8,1,2'd1,16'd1));
        sv.push_back(st(1,8,3,9, 1,0,1,0,0, 1,0, 9,1,0,0,0,2'd0,16'd1));
        sv.push_back(st(1,0,0,4, 1,1,0,0,0, 1,0, 4,1,1,9,1,2'd0,16'd1));
        sv.push_back(st(1,1,4,6, 1,0,0,0,0, 1,0, 6,1,0,4,1,2'd0,16'd1));
        sv.push_back(st(1,0,0,4, 1,1,0,0,0, 1,0, 4,1,1,6,1,2'd0,16'd1));
        sv.push_back(st(1,1,4,6, 1,0,1,0,0, 0,1, 0,0,0,4,1,2'd1,16'd2));
        sv.push_back(st(1,1,4,6, 1,0,1,0,0, 1,0, 6,1,0,0,0,2'd0,16'd2));
        foreach (sv[i]) begin
            drive(sv[i]);
            #1;
            n_cmp++;
            if ({pc_write, if_id_write, lu_stall} !== {sv[i].en, sv[i].en, sv[i].lu}) begin
                n_bad++;
                $display("FAIL loaduse_comb[%0d]: got pc/ifid/lu=%b%b%b want %b%b%b", i,
                         pc_write, if_id_write, lu_stall, sv[i].en, sv[i].en, sv[i].lu);
            end
            q.push_back(sv[i].exp);
            tick();
            e = q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL loaduse_regs[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_flush();
        step_t sv[$];
        sv.push_back(st(1,0,0,8, 1,1,0,0,0, 1,0, 8,1,1,6,1,2'd0,16'd2));
        sv.push_back(st(1,8,0,9, 1,0,0,1,0, 1,0, 0,0,0,8,1,2'd0,16'd2));
        sv.push_back(st(0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,0,0,2'd0,16'd2));
        foreach (sv[i]) begin
            drive(sv[i]);
            #1;
            n_cmp++;
            if ({pc_write, if_id_write, lu_stall} !== {sv[i].en, sv[i].en, sv[i].lu}) begin
                n_bad++;
                $display("FAIL flush_comb[%0d]: got pc/ifid/lu=%b%b%b want %b%b%b", i,
                         pc_write, if_id_write, lu_stall, sv[i].en, sv[i].en, sv[i].lu);
            end
            q.push_back(sv[i].exp);
            tick();
            e = q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL flush_regs[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_freeze();
        step_t sv[$];
        sv.push_back(st(1,0,0,10, 1,0,0,0,0, 1,0, 10,1,0,0,0,2'd0,16'd2));
        sv.push_back(st(1,0,0,11, 1,1,0,0,0, 1,0, 11,1,1,10,1,2'd0,16'd2));
        sv.push_back(st(1,11,0,12, 1,0,0,0,1, 0,0, 11,1,1,10,1,2'd2,16'd3));
        sv.push_back(st(1,11,0,12, 1,0,0,0,1, 0,0, 11,1,1,10,1,2'd2,16'd4));
        sv.push_back(st(1,11,0,12, 1,0,0,0,1, 0,0, 11,1,1,10,1,2'd2,16'd5));
        sv.push_back(st(1,11,0,12, 1,0,0,0,0, 0,1, 0,0,0,11,1,2'd1,16'd6));
        sv.push_back(st(1,11,0,12, 1,0,0,0,0, 1,0, 12,1,0,0,0,2'd0,16'd6));
        foreach (sv[i]) begin
            drive(sv[i]);
            #1;
            n_cmp++;
            if ({pc_write, if_id_write, lu_stall} !== {sv[i].en, sv[i].en, sv[i].lu}) begin
                n_bad++;
                $display("FAIL freeze_comb[%0d]: got pc/ifid/lu=%b%b%b want %b%b%b", i,
                         pc_write, if_id_write, lu_stall, sv[i].en, sv[i].en, sv[i].lu);
            end
            q.push_back(sv[i].exp);
            tick();
            e = q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL freeze_regs[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_zero_and_saturation();
        step_t sv[$];
        sv.push_back(st(1,0,0,0, 1,1,0,0,0, 1,0, 0,0,1,12,1,2'd0,16'd6));
        sv.push_back(st(1,0,0,0, 0,0,1,0,0, 1,0, 0,0,0,0,0,2'd0,16'd6));
        foreach (sv[i]) begin
            drive(sv[i]);
            #1;
            n_cmp++;
            if ({pc_write, if_id_write, lu_stall} !== {sv[i].en, sv[i].en, sv[i].lu}) begin
                n_bad++;
                $display("FAIL zero_comb[%0d]: got pc/ifid/lu=%b%b%b want %b%b%b", i,
                         pc_write, if_id_write, lu_stall, sv[i].en, sv[i].en, sv[i].lu);
            end
            q.push_back(sv[i].exp);
            tick();
            e = q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL zero_regs[%0d]: got %h want %h", i, o, e);
            end
        end
        drive(st(0,0,0,0, 0,0,0,0,1, 0,0, 0,0,0,0,0,2'd2,16'hFFFF));
        q.push_back({5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd2, 16'hFFFF});
        for (int k = 0; k < 65540; k++) tick();
        e = q.pop_front();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL sat_reach: got %h want %h", o, e);
        end
        sv.delete();
        sv.push_back(st(0,0,0,0, 0,0,0,0,1, 0,0, 0,0,0,0,0,2'd2,16'hFFFF));
        sv.push_back(st(0,0,0,0, 0,0,0,0,0, 1,0, 0,0,0,0,0,2'd0,16'hFFFF));
        foreach (sv[i]) begin
            drive(sv[i]);
            #1;
            n_cmp++;
            if ({pc_write, if_id_write, lu_stall} !== {sv[i].en, sv[i].en, sv[i].lu}) begin
                n_bad++;
                $display("FAIL sat_comb[%0d]: got pc/ifid/lu=%b%b%b want %b%b%b", i,
                         pc_write, if_id_write, lu_stall, sv[i].en, sv[i].en, sv[i].lu);
            end
            q.push_back(sv[i].exp);
            tick();
            e = q.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL sat_regs[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_flush();
        test_freeze();
        test_zero_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_dest_pipe.md
Name: hazard_dest_pipe

Overview:
- Producer side of the EX/MEM forwarding interface: carries destination-register and write-control fields from ID through the EX, MEM and WB stages.
- Drives the ex_*/mem_* signals that the forwarding comparator consumes.
- Detects load-use hazards, inserts bubbles, honours branch flush and global memory stall.
- Drives PC and IF/ID write enables, and counts stall cycles for performance monitoring.

Parameters:
- RD_W, 5, register-index width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RD_W  ID source register 1.
- id_rt  in  RD_W  ID source register 2.
- id_rd  in  RD_W  ID destination register (already muxed rt/rd).
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- flush_ex  in  1  branch resolved taken; the ID instruction must not enter EX.
- ext_stall  in  1  memory not ready; freeze the whole pipe.
- ex_rd  out  RD_W  EX-stage destination.
- ex_reg_write  out  1  EX-stage write enable.
- ex_mem_read  out  1  EX-stage load flag.
- mem_rd  out  RD_W  MEM-stage destination.
- mem_reg_write  out  1  MEM-stage write enable.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register write enable.
- lu_stall  out  1  load-use stall active this cycle.
- state  out  2  FSM state: 0 RUN, 1 LU, 2 HOLD.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst=1): every registered output is 0, including all *_rd, *_reg_write, ex_mem_read, stall_cnt and the optional WB fields; state=RUN.
  - pc_write=1 and if_id_write=1 while in reset, since they are combinational with no hazard.
  - Asserting rst mid-stall discards the bubble and returns the FSM to RUN.
- Write-enable canonicalisation: ex_reg_write loads id_valid & id_reg_write & (id_rd!=0). An $zero destination therefore never appears as a live write.
- Load-use hazard: hz = id_valid & ex_mem_read & ex_reg_write & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Priority per cycle: ext_stall > flush_ex > hz > normal advance.
- ext_stall=1:
  - All stage registers hold; pc_write=0, if_id_write=0, lu_stall=0.
  - Next state=HOLD.
- flush_ex=1 (no ext_stall):
  - EX loads a bubble: rd=0, reg_write=0, mem_read=0. MEM loads from EX.
  - pc_write=1, if_id_write=1, lu_stall=0 even if hz=1.
  - Next state=RUN.
- hz=1 (no ext_stall, no flush):
  - EX loads a bubble; MEM loads from EX.
  - pc_write=0, if_id_write=0, lu_stall=1; next state=LU.
  - The hazard clears after exactly one bubble because ex_mem_read becomes 0, so load-use latency is 1 cycle.
- Normal: EX loads from ID; MEM loads from EX; enables=1; next state=RUN.
- stall_cnt increments by 1 in every cycle where lu_stall=1 or ext_stall=1, and saturates at all-ones (no wrap).
- pc_write, if_id_write and lu_stall are combinational from the current registers and inputs, valid in the same cycle.

Optional Feature:
- WB_FWD_EN defined:
  - Adds outputs wb_rd (RD_W) and wb_reg_write (1), loaded from MEM on advance, reset to 0, held under ext_stall.
  - These feed a third forwarding source.
- WB_FWD_EN undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> all outputs 0, state=0, pc_write=1.
- Back-to-back ALU writes:
  - Stimulus: id_rd=5, id_reg_write=1, id_valid=1 for 2 cycles.
  - Response: ex_rd=5/ex_reg_write=1 after edge 1; mem_rd=5 after edge 2; lu_stall never 1.
- Load-use:
  - Stimulus: load to r8 (id_mem_read=1), then ID with id_rs=8.
  - Response: lu_stall=1, pc_write=0 for exactly 1 cycle; ex_rd=0 next cycle; stall_cnt=1; dependent instruction enters EX one cycle later.
- Flush over hazard: same load-use setup with flush_ex=1 -> lu_stall=0, pc_write=1, EX bubble, stall_cnt unchanged.
- Freeze: ext_stall=1 for 3 cycles with live EX/MEM -> ex_rd/mem_rd unchanged, state=2, stall_cnt+=3; release resumes advance.
- $zero and saturation:
  - id_rd=0 with id_reg_write=1 -> ex_reg_write=0.
  - Preload stall_cnt to 16'hFFFF via a long ext_stall -> it stays 16'hFFFF.
